// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Entry layout is what the prefetch FIFO stores per instruction.
package fetch_pkg;

  localparam int PC_W        = 32;
  localparam int DATA_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched instructions with their PCs.
// Flush clears everything; entries are read from the head combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited imem requests,
// buffers responses and drops stale ones after a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              PC_W       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [PC_W-1:0]   instr_pc,
  input  logic              instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] resp_pc;
  logic [PC_W-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     used;
  logic            req_fire;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  assign used     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign target   = {redirect_pc[PC_W-1:2], 2'b00};

  assign imem_req_valid = !reset && !redirect_valid
                       && (used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_drop = (drop_cnt != '0);
  assign push      = imem_resp_valid && !resp_drop
                  && !redirect_valid;
  assign pop       = instr_valid && instr_ready;

  assign wdata.pc    = resp_pc;
  assign wdata.instr = imem_resp_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wdata),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (head),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

  assign instr_valid = !empty;
  assign instr_data  = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire)
                   - CW'(imem_resp_valid);
      unique case (1'b1)
        // in-flight responses, minus one landing now, become stale
        redirect_valid: begin
          fetch_pc <= target;
          resp_pc  <= target;
          drop_cnt <= outstanding - CW'(imem_resp_valid);
        end
        default: begin
          if (req_fire) begin
            fetch_pc <= fetch_pc + PC_W'(INSTR_BYTES);
          end
          if (push) begin
            resp_pc <= resp_pc + PC_W'(INSTR_BYTES);
          end
          if (imem_resp_valid && resp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && imem_resp_valid) begin
      assert (outstanding != '0)
        else $error("imem response with none outstanding");
    end
    if (!reset && push && !pop) begin
      assert (!full)
        else $error("imem response into full fifo");
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a
// queue-based model of memory and the expected instruction stream.
module tb_instr_fetch_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DATA_W     (32),
    .PC_W       (32),
    .FIFO_DEPTH (D),
    .RESET_PC   (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  typedef struct {
    logic [31:0] pc;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        mq[$];
  ent_t        bq[$];
  int          cyc;
  int          epoch;
  int          checks;
  int          errors;
  int          lat_lo;
  int          lat_hi;
  int          dut_acc;
  logic [31:0] nxt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rdy, input bit mrdy,
                      input bit redir, input logic [31:0] tgt);
    bit   exp_req;
    req_t r;
    instr_ready     = rdy;
    imem_req_ready  = mrdy;
    redirect_valid  = redir;
    redirect_pc     = tgt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEADBEEF;
    if (mq.size() != 0) begin
      if (mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memf(mq[0].pc);
      end
    end
    #2;
    chk("instr_valid", instr_valid, bq.size() != 0);
    if (bq.size() != 0) begin
      chk("instr_pc", instr_pc, bq[0].pc);
      chk("instr_data", instr_data, bq[0].data);
    end
    exp_req = !redir && (mq.size() + bq.size() < D);
    chk("req_valid", imem_req_valid, exp_req);
    if (imem_req_valid) chk("req_addr", imem_req_addr, nxt);
    if (imem_req_valid && mrdy) dut_acc++;
    if (rdy && bq.size() != 0) void'(bq.pop_front());
    if (imem_resp_valid) begin
      r = mq.pop_front();
      if (r.ep == epoch && !redir)
        bq.push_back('{pc: r.pc, data: memf(r.pc)});
    end
    if (redir) begin
      bq.delete();
      epoch++;
      nxt = {tgt[31:2], 2'b00};
    end
    if (exp_req && mrdy) begin
      mq.push_back('{pc: nxt,
                     due: cyc + int'($urandom_range(lat_hi, lat_lo)),
                     ep: epoch});
      nxt = nxt + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    instr_ready     = 1'b0;
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    mq.delete();
    bq.delete();
    nxt = '0;
    epoch++;
    dut_acc = 0;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_data", instr_data, 32'h0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !instr_valid; i++) tick(1, 1, 0, 0);
    chk(tag, instr_valid, 1);
  endtask

  initial begin
    reset = 1'b1;
    checks = 0; errors = 0; cyc = 0; epoch = 0;
    lat_lo = 1; lat_hi = 1;

    // streaming at latency 1
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 32'h0);
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0);

    // core stalled: credit caps requests at depth
    do_reset();
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
    chk("stall_accepts", dut_acc, 4);
    chk("stall_req_valid", imem_req_valid, 0);
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0);

    // memory back-pressure holds address
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0);
      chk("hold_addr", imem_req_addr, 32'h8);
      chk("hold_valid", imem_req_valid, 1);
    end
    tick(1, 1, 0, 0);
    chk("after_hold_addr", imem_req_addr, 32'hC);

    // redirect with two stale requests in flight
    lat_lo = 3; lat_hi = 3;
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 1, 32'h103);
    chk("redir_flush", instr_valid, 0);
    wait_valid("redir_wait0");
    chk("redir_pc0", instr_pc, 32'h100);
    tick(1, 1, 0, 0);
    wait_valid("redir_wait1");
    chk("redir_pc1", instr_pc, 32'h104);

    // redirect coincides with response and core handshake
    lat_lo = 2; lat_hi = 2;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 1, 0, 0);
    chk("pre_redir_valid", instr_valid, 1);
    tick(1, 1, 1, 32'h200);
    wait_valid("same_wait");
    chk("same_pc", instr_pc, 32'h200);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);

    // reset mid-stream
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 10 && bq.size() < 3; i++) tick(0, 1, 0, 0);
    chk("mid_fill", instr_valid, 1);
    do_reset();
    wait_valid("restart_wait");
    chk("restart_pc", instr_pc, 32'h0);

    // randomized traffic
    lat_lo = 1; lat_hi = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 10) < 7, ($urandom % 10) < 7,
           ($urandom % 40) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
